// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl -- read-domain controller of an asynchronous FIFO.
// Synchronises the write Gray pointer, keeps the binary/Gray read pointers and
// the empty flag, and drives the RAM read port. A small FSM presents each word
// to the consumer with valid/ready handshaking. A hold register keeps a
// stalled word stable after the RAM output has moved on.
// Optional feature: define FIFO_RD_LEVEL_EN to add the registered rd_level
// output (words still held in the RAM, seen from the read side).
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic [ADDR_WIDTH:0]   wptr_gray,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  empty
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   rd_level
`endif
);

  // IDLE: nothing to offer; FRESH: word is on ram_rdata; HELD: word in hold_r
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRESH = 2'd1,
    HELD  = 2'd2
  } rd_state_e;

  rd_state_e             state_r;
  logic                  rd_valid_r;
  logic [DATA_WIDTH-1:0] hold_r;

  logic [ADDR_WIDTH:0]   wq1_wptr_r;
  logic [ADDR_WIDTH:0]   wq2_wptr_r;
  logic [ADDR_WIDTH:0]   rbin_r;
  logic [ADDR_WIDTH:0]   rbin_next_s;
  logic [ADDR_WIDTH:0]   rgray_next_s;
  logic                  ren_s;

`ifdef FIFO_RD_LEVEL_EN
  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] gray);
    logic [ADDR_WIDTH:0] bin;
    bin[ADDR_WIDTH] = gray[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      bin[i] = bin[i + 1] ^ gray[i];
    end
    return bin;
  endfunction
`endif

  assign raddr = rbin_r[ADDR_WIDTH-1:0];
  assign ren   = ren_s;

  // Read enable: a word exists and the output slot is free or being emptied
  always_comb begin
    ren_s = 1'b0;
    if (r_rst) begin
      ren_s = 1'b0;
    end else begin
      ren_s = !empty && (!rd_valid_r || rd_ready);
    end
  end

  // Next read pointer in binary and Gray form
  always_comb begin
    rbin_next_s  = rbin_r + {{ADDR_WIDTH{1'b0}}, ren_s};
    rgray_next_s = {1'b0, rbin_next_s[ADDR_WIDTH:1]} ^ rbin_next_s;
  end

  // Two-flop synchroniser bringing the write Gray pointer into r_clk
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      wq1_wptr_r <= {(ADDR_WIDTH + 1){1'b0}};
      wq2_wptr_r <= {(ADDR_WIDTH + 1){1'b0}};
    end else begin
      wq1_wptr_r <= wptr_gray;
      wq2_wptr_r <= wq1_wptr_r;
    end
  end

  // Read pointers and empty flag; empty compares the post-read Gray pointer
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      rbin_r    <= {(ADDR_WIDTH + 1){1'b0}};
      rptr_gray <= {(ADDR_WIDTH + 1){1'b0}};
      empty     <= 1'b1;
    end else begin
      rbin_r    <= rbin_next_s;
      rptr_gray <= rgray_next_s;
      empty     <= (rgray_next_s == wq2_wptr_r);
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  // Words left in the RAM after this cycle's read, modulo the pointer range
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      rd_level <= {(ADDR_WIDTH + 1){1'b0}};
    end else begin
      rd_level <= gray2bin(wq2_wptr_r) - rbin_next_s;
    end
  end
`endif

  // Output FSM: a read always lands in FRESH; a stalled FRESH word moves to hold_r
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_r    <= IDLE;
      rd_valid_r <= 1'b0;
      hold_r     <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (ren_s) begin
            state_r    <= FRESH;
            rd_valid_r <= 1'b1;
          end else begin
            state_r    <= IDLE;
            rd_valid_r <= 1'b0;
          end
        end
        FRESH: begin
          if (ren_s) begin
            state_r    <= FRESH;
            rd_valid_r <= 1'b1;
          end else if (rd_ready) begin
            state_r    <= IDLE;
            rd_valid_r <= 1'b0;
          end else begin
            state_r    <= HELD;
            rd_valid_r <= 1'b1;
            hold_r     <= ram_rdata;
          end
        end
        HELD: begin
          if (ren_s) begin
            state_r    <= FRESH;
            rd_valid_r <= 1'b1;
          end else if (rd_ready) begin
            state_r    <= IDLE;
            rd_valid_r <= 1'b0;
          end else begin
            state_r    <= HELD;
            rd_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          rd_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Consumer outputs: forced quiet during reset, otherwise selected by state
  always_comb begin
    rd_data  = {DATA_WIDTH{1'b0}};
    rd_valid = 1'b0;
    if (r_rst) begin
      rd_data  = {DATA_WIDTH{1'b0}};
      rd_valid = 1'b0;
    end else begin
      rd_valid = rd_valid_r;
      case (state_r)
        FRESH:   rd_data = ram_rdata;
        HELD:    rd_data = hold_r;
        IDLE:    rd_data = hold_r;
        default: rd_data = {DATA_WIDTH{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Testbench for fifo_rd_ctrl: behavioural RAM plus a write-side model that
// pushes expected words into a scoreboard queue; words accepted by the
// consumer are popped and compared every cycle.
module tb_fifo_rd_ctrl;

  logic       r_clk;
  logic       r_rst;
  logic [4:0] wptr_gray;
  logic [4:0] rptr_gray;
  logic       ren;
  logic [3:0] raddr;
  logic [7:0] ram_rdata;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       empty;
`ifdef FIFO_RD_LEVEL_EN
  logic [4:0] rd_level;
`endif

  int         n_checks;
  int         n_errors;
  logic [7:0] mem [0:15];
  logic [7:0] sb_q [$];
  logic [4:0] wbin;

  fifo_rd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .r_clk     (r_clk),
    .r_rst     (r_rst),
    .wptr_gray (wptr_gray),
    .rptr_gray (rptr_gray),
    .ren       (ren),
    .raddr     (raddr),
    .ram_rdata (ram_rdata),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .empty     (empty)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .rd_level  (rd_level)
`endif
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  // RAM: data valid only in the cycle after ren, garbage otherwise
  always @(posedge r_clk) begin
    if (ren) ram_rdata <= mem[raddr];
    else     ram_rdata <= 8'($urandom);
  end

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  // Scoreboard compare of any word accepted by the consumer this cycle
  task automatic sb_check();
    logic [7:0] exp;
    if (rd_valid && rd_ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_extra: rd_data=%h accepted, no word expected", rd_data);
      end else begin
        exp = sb_q.pop_front();
        if (rd_data !== exp) begin
          n_errors++;
          $display("FAIL sb_data: rd_data=%h required %h", rd_data, exp);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge r_clk);
    sb_check();
    @(posedge r_clk);
    #2;
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[wbin[3:0]] = d;
    sb_q.push_back(d);
    wbin      = wbin + 5'd1;
    wptr_gray = to_gray(wbin);
  endtask

  task automatic do_reset(input int cycles);
    r_rst     = 1'b1;
    rd_ready  = 1'b0;
    wbin      = 5'd0;
    wptr_gray = 5'd0;
    sb_q.delete();
    repeat (cycles) tick();
    r_rst = 1'b0;
    #1;
  endtask

  task automatic wait_ren(input int limit, output int cycles);
    cycles = 0;
    while (!ren && cycles < limit) begin
      tick();
      cycles++;
    end
    n_checks++;
    if (!ren) begin
      n_errors++;
      $display("FAIL wait_ren: ren=%0b after %0d cycles, required 1", ren, cycles);
    end
  endtask

  task automatic test_reset();
    r_rst = 1'b1;
    rd_ready = 1'b0;
    wbin = 5'd0;
    wptr_gray = 5'd0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (ren !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
        n_errors++;
        $display("FAIL reset_hold: ren=%0b rd_valid=%0b rd_data=%h required 0/0/00", ren, rd_valid, rd_data);
      end
    end
    n_checks++;
    if (empty !== 1'b1 || rptr_gray !== 5'd0) begin
      n_errors++;
      $display("FAIL reset_state: empty=%0b rptr_gray=%b required 1/00000", empty, rptr_gray);
    end
    r_rst = 1'b0;
    #1;
    n_checks++;
    if (ren !== 1'b0 || rd_valid !== 1'b0 || empty !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release: ren=%0b rd_valid=%0b empty=%0b required 0/0/1", ren, rd_valid, empty);
    end
  endtask

  task automatic test_single_word();
    int ren_cycles = 0;
    int valid_cycles = 0;
    int first = -1;
    rd_ready = 1'b1;
    push_word(8'hA5);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (ren) begin
        ren_cycles++;
        if (first < 0) first = c;
        n_checks++;
        if (raddr !== 4'd0) begin
          n_errors++;
          $display("FAIL single_raddr: raddr=%0d required 0", raddr);
        end
      end
      if (rd_valid) valid_cycles++;
    end
    n_checks++;
    if (ren_cycles != 1 || valid_cycles != 1) begin
      n_errors++;
      $display("FAIL single_counts: ren cycles=%0d valid cycles=%0d required 1/1", ren_cycles, valid_cycles);
    end
    n_checks++;
    if (first < 3 || first > 4) begin
      n_errors++;
      $display("FAIL single_latency: ren after %0d cycles required 3..4", first);
    end
    n_checks++;
    if (rptr_gray !== 5'b00001 || empty !== 1'b1) begin
      n_errors++;
      $display("FAIL single_ptr: rptr_gray=%b empty=%0b required 00001/1", rptr_gray, empty);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    rd_ready = 1'b0;
    push_word(8'hB0);
    push_word(8'hB1);
    push_word(8'hB2);
    wait_ren(10, cyc);
    tick();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (ren !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 8'hB0) begin
        n_errors++;
        $display("FAIL bp_stall c=%0d: ren=%0b rd_valid=%0b rd_data=%h required 0/1/b0", c, ren, rd_valid, rd_data);
      end
      tick();
    end
    rd_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (rd_valid !== (k < 3)) begin
        n_errors++;
        $display("FAIL bp_release k=%0d: rd_valid=%0b required %0b", k, rd_valid, (k < 3));
      end
      tick();
    end
  endtask

  task automatic test_stream();
    int cyc;
    do_reset(2);
    rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) push_word(8'(8'h40 + k));
    wait_ren(10, cyc);
    n_checks++;
    if (cyc < 3 || cyc > 4) begin
      n_errors++;
      $display("FAIL stream_latency: ren after %0d cycles required 3..4", cyc);
    end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (ren !== (i < 16) || (i < 16 && raddr !== 4'(i))) begin
        n_errors++;
        $display("FAIL stream_ren i=%0d: ren=%0b raddr=%0d required %0b/%0d", i, ren, raddr, (i < 16), i);
      end
      n_checks++;
      if (rd_valid !== (i >= 1 && i <= 16)) begin
        n_errors++;
        $display("FAIL stream_valid i=%0d: rd_valid=%0b", i, rd_valid);
      end
`ifdef FIFO_RD_LEVEL_EN
      n_checks++;
      if (rd_level !== ((i <= 16) ? 5'(16 - i) : 5'd0)) begin
        n_errors++;
        $display("FAIL stream_level i=%0d: rd_level=%0d required %0d", i, rd_level, (i <= 16) ? (16 - i) : 0);
      end
`endif
      tick();
    end
    n_checks++;
    if (empty !== 1'b1 || rptr_gray !== 5'b11000) begin
      n_errors++;
      $display("FAIL stream_end: empty=%0b rptr_gray=%b required 1/11000", empty, rptr_gray);
    end
  endtask

  task automatic test_wrap();
    int   pushed = 0;
    int   guard = 0;
    logic wrapped = 1'b0;
    logic [4:0] prev_g;
    prev_g = rptr_gray;
    while ((pushed < 40 || sb_q.size() != 0) && guard < 2000) begin
      if (pushed < 40 && sb_q.size() <= 8) begin
        for (int k = 0; k < 8; k++) push_word(8'($urandom));
        pushed += 8;
      end
      rd_ready = 1'($urandom_range(0, 1));
      tick();
      if (prev_g == 5'b10000 && rptr_gray == 5'b00000) wrapped = 1'b1;
      prev_g = rptr_gray;
`ifdef FIFO_RD_LEVEL_EN
      n_checks++;
      if (rd_level > 5'd16) begin
        n_errors++;
        $display("FAIL wrap_level: rd_level=%0d required <= 16", rd_level);
      end
`endif
      guard++;
    end
    rd_ready = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (guard >= 2000 || sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL wrap_timeout: %0d words still expected, required 0", sb_q.size());
    end
    n_checks++;
    if (wrapped !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_ptr: pointer wrap 31->0 seen=%0b required 1", wrapped);
    end
    n_checks++;
    if (rptr_gray !== to_gray(wbin) || empty !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_end: rptr_gray=%b empty=%0b required %b/1", rptr_gray, empty, to_gray(wbin));
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int stray = 0;
    rd_ready = 1'b0;
    push_word(8'h3C);
    wait_ren(10, cyc);
    tick();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
      n_errors++;
      $display("FAIL mid_fresh: rd_valid=%0b rd_data=%h required 1/3c", rd_valid, rd_data);
    end
    r_rst = 1'b1;
    wbin = 5'd0;
    wptr_gray = 5'd0;
    sb_q.delete();
    #1;
    n_checks++;
    if (rd_valid !== 1'b0 || ren !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_in_reset: rd_valid=%0b ren=%0b required 0/0", rd_valid, ren);
    end
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || rptr_gray !== 5'd0 || raddr !== 4'd0 || empty !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_reset: rd_valid=%0b rptr_gray=%b raddr=%0d empty=%0b required 0/00000/0/1", rd_valid, rptr_gray, raddr, empty);
    end
    tick();
    r_rst = 1'b0;
    rd_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rd_valid || ren) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_errors++;
      $display("FAIL mid_restart: %0d cycles with rd_valid/ren after reset, required 0", stray);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    r_rst = 1'b1;
    rd_ready = 1'b0;
    wbin = 5'd0;
    wptr_gray = 5'd0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_single_word();
    test_backpressure();
    test_stream();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
